// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and index-width helper for the handshake arbiter
package arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, GUARD} arb_state_t;
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: masked/unmasked double priority encoder selecting the next grant winner
module rr_pick
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter bit RR_MODE = 1'b1,
   parameter int PW = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic               found,
   output logic [PW-1:0]      winner
);
   logic [NUM_REQ-1:0] masked;
   logic [PW-1:0] hi_idx;
   logic [PW-1:0] lo_idx;
   always_comb begin
      masked = '0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) masked[i] = req[i] & (!RR_MODE || i >= int'(ptr));
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (masked[i]) hi_idx = PW'(i);
         if (req[i]) lo_idx = PW'(i);
      end
   end
   assign found  = |req;
   assign winner = (|masked) ? hi_idx : lo_idx;
endmodule

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: N-way registered one-hot arbiter with guard cycle and optional hold timeout
module rr_handshake_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter bit RR_MODE  = 1'b1,
   parameter int MAX_HOLD = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic                       busy,
   output logic                       timeout
);
   localparam int PW = idx_w(NUM_REQ);
   localparam int CW = idx_w(MAX_HOLD + 1);
   localparam bit HOLD_EN = MAX_HOLD != 0;
   localparam logic [CW-1:0] LAST = CW'(HOLD_EN ? MAX_HOLD - 1 : 0);
   arb_state_t state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0] id_q, id_d, ptr_q, ptr_d, win, nxt_ptr;
   logic [CW-1:0] cnt_q, cnt_d;
   logic to_q, to_d;
   logic found, grant, release_w, expire, done;
   rr_pick #(.NUM_REQ(NUM_REQ), .RR_MODE(RR_MODE), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .found  (found),
      .winner (win)
   );
   assign grant     = (state_q == IDLE) && found;
   assign release_w = (state_q == BUSY) && !req[id_q];
   assign expire    = (state_q == BUSY) && req[id_q] && HOLD_EN && (cnt_q == LAST);
   assign done      = release_w || expire;
   assign nxt_ptr   = (id_q == PW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (found ? BUSY : IDLE) :
                (state_q == BUSY) ? (done ? GUARD : BUSY) : IDLE;
   end
   // counter saturates so a long hold with the timeout disabled never wraps
   always_comb begin
      gnt_d = grant ? NUM_REQ'(1) << win : done ? '0 : gnt_q;
      id_d  = grant ? win : done ? '0 : id_q;
      cnt_d = grant ? '0 : ((state_q == BUSY) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      ptr_d = (done && RR_MODE) ? nxt_ptr : ptr_q;
      to_d  = expire;
   end
   assign gnt     = gnt_q;
   assign gnt_id  = id_q;
   assign busy    = |gnt_q;
   assign timeout = to_q;
endmodule
